// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the set-associative dcache.
package dcache_pkg;
   localparam int LINE_W   = 256;
   localparam int WORD_W   = 32;
   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} cacheState_t;

   // Set index of a byte address, right-aligned
   function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int idxW);
      return (addr >> OFFSET_W) & ((32'd1 << idxW) - 32'd1);
   endfunction

   // Tag of a byte address, right-aligned
   function automatic logic [31:0] addrTag(input logic [31:0] addr, input int idxW);
      return addr >> (OFFSET_W + idxW);
   endfunction

   // 32-bit word of a line selected by addr[4:2]
   function automatic logic [WORD_W-1:0] lineWord(input logic [LINE_W-1:0] line,
                                                  input logic [2:0] sel);
      return line[sel*WORD_W +: WORD_W];
   endfunction
endpackage

// File: rtl/dcache_sa_array.sv
// Tag/valid/dirty/data storage for WAYS x SETS lines: all ways read at one
// index combinationally, one write port for a line fill or a word store.
module dcache_sa_array
   import dcache_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int SETS  = 16,
   parameter int IDX_W = 4,
   parameter int TAG_W = 23,
   parameter int WAY_W = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [IDX_W-1:0]               rdIdx,
   output logic [WAYS-1:0]                rdValid,
   output logic [WAYS-1:0]                rdDirty,
   output logic [WAYS-1:0][TAG_W-1:0]     rdTag,
   output logic [WAYS-1:0][LINE_W-1:0]    rdLine,
   input  logic                           wrEn,
   input  logic [WAY_W-1:0]               wrWay,
   input  logic [IDX_W-1:0]               wrIdx,
   input  logic                           wrLineEn,
   input  logic [LINE_W-1:0]              wrLine,
   input  logic                           wrWordEn,
   input  logic [2:0]                     wrWordSel,
   input  logic [WORD_W-1:0]              wrWord,
   input  logic                           wrValid,
   input  logic                           wrDirty,
   input  logic [TAG_W-1:0]               wrTag
);
   for (genvar w = 0; w < WAYS; w++) begin : gWay
      logic              valid   [SETS];
      logic              dirty   [SETS];
      logic [TAG_W-1:0]  tag     [SETS];
      logic [LINE_W-1:0] lineMem [SETS];
      logic              sel;

      assign sel = wrEn && (wrWay == WAY_W'(w));

      // Metadata: cleared by reset, rewritten on every write to this way
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
               valid[s] <= 1'b0;
               dirty[s] <= 1'b0;
               tag[s]   <= '0;
            end
         end else if (sel) begin
            valid[wrIdx] <= wrValid;
            dirty[wrIdx] <= wrDirty;
            tag[wrIdx]   <= wrTag;
         end
      end

      // Line data: content is meaningless until valid, so no reset
      always_ff @(posedge clk_i) begin
         if (sel && wrLineEn)
            lineMem[wrIdx] <= wrLine;
         else if (sel && wrWordEn)
            lineMem[wrIdx][wrWordSel*WORD_W +: WORD_W] <= wrWord;
      end

      assign rdValid[w] = valid[rdIdx];
      assign rdDirty[w] = dirty[rdIdx];
      assign rdTag[w]   = tag[rdIdx];
      assign rdLine[w]  = lineMem[rdIdx];
   end
endmodule

// File: rtl/dcache_sa_controller.sv
// Set-associative write-back/write-allocate dcache controller with per-set
// LRU: hit compare, victim choice, LRU ages and the miss-service FSM.
module dcache_sa_controller
   import dcache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   input  logic              cpu_MemRead_i,
   input  logic              cpu_MemWrite_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [31:0]       mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - OFFSET_W - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int AGE_W = WAY_W;

   cacheState_t               state, stateNext;
   logic [WAY_W-1:0]          vicWay, vicWayQ, hitWay, lruWay;
   logic                      wbGapQ, lruTouch, req, hit;
   logic [AGE_W-1:0]          maxAge;
   logic [AGE_W-1:0]          age [SETS][WAYS];
   logic [IDX_W-1:0]          reqIdx;
   logic [TAG_W-1:0]          reqTag;
   logic [2:0]                wordSel;
   logic [WAYS-1:0]           rdValid, rdDirty, hitVec;
   logic [WAYS-1:0][TAG_W-1:0]  rdTag;
   logic [WAYS-1:0][LINE_W-1:0] rdLine;
   logic                      wrEn, wrLineEn, wrWordEn, wrValid, wrDirty;
   logic [WAY_W-1:0]          wrWay;
   logic [TAG_W-1:0]          wrTag;
   logic [1:0]                unusedByteOffset;

   assign reqIdx  = IDX_W'(addrIndex(cpu_addr_i, IDX_W));
   assign reqTag  = TAG_W'(addrTag(cpu_addr_i, IDX_W));
   assign wordSel = cpu_addr_i[4:2];
   assign req     = cpu_MemRead_i || cpu_MemWrite_i;
   assign unusedByteOffset = cpu_addr_i[1:0];

   dcache_sa_array #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .WAY_W(WAY_W)) uArray (
      .clk_i(clk_i), .rst_i(rst_i), .rdIdx(reqIdx),
      .rdValid(rdValid), .rdDirty(rdDirty), .rdTag(rdTag), .rdLine(rdLine),
      .wrEn(wrEn), .wrWay(wrWay), .wrIdx(reqIdx), .wrLineEn(wrLineEn), .wrLine(mem_data_i),
      .wrWordEn(wrWordEn), .wrWordSel(wordSel), .wrWord(cpu_data_i),
      .wrValid(wrValid), .wrDirty(wrDirty), .wrTag(wrTag)
   );

   for (genvar w = 0; w < WAYS; w++) begin : gCmp
      assign hitVec[w] = rdValid[w] && (rdTag[w] == reqTag);
   end
   assign hit = |hitVec;

   // Encode the (unique) matching way
   always_comb begin
      hitWay = '0;
      for (int w = 0; w < WAYS; w++)
         if (hitVec[w]) hitWay = WAY_W'(w);
   end

   // Victim: lowest invalid way, else the oldest way of the set
   always_comb begin
      vicWay = '0;
      maxAge = age[reqIdx][0];
      for (int w = 1; w < WAYS; w++)
         if (age[reqIdx][w] > maxAge) begin
            maxAge = age[reqIdx][w];
            vicWay = WAY_W'(w);
         end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!rdValid[w]) vicWay = WAY_W'(w);
   end

   assign cpu_data_o = (state == IDLE && cpu_MemRead_i && hit) ? lineWord(rdLine[hitWay], wordSel) : '0;

   // Next state, memory request, array write port and LRU strobe
   always_comb begin
      stateNext    = state;
      cpu_stall_o  = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      wrEn         = 1'b0;
      wrWay        = hitWay;
      wrLineEn     = 1'b0;
      wrWordEn     = 1'b0;
      wrValid      = 1'b1;
      wrDirty      = 1'b0;
      wrTag        = reqTag;
      lruTouch     = 1'b0;
      lruWay       = hitWay;
      case (state)
         IDLE: begin
            if (req && hit) begin
               lruTouch = 1'b1;
               if (cpu_MemWrite_i) begin
                  wrEn     = 1'b1;
                  wrWordEn = 1'b1;
                  wrDirty  = 1'b1;
               end
            end else if (req) begin
               cpu_stall_o = 1'b1;
               stateNext   = (rdValid[vicWay] && rdDirty[vicWay]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rdTag[vicWayQ], reqIdx, 5'b0};
            mem_data_o   = rdLine[vicWayQ];
            if (mem_ack_i) begin
               wrEn      = 1'b1;
               wrWay     = vicWayQ;
               wrTag     = rdTag[vicWayQ];
               stateNext = ALLOCATE;
            end
         end
         ALLOCATE: begin
            cpu_stall_o = 1'b1;
            // First cycle after a writeback is the mandatory enable gap
            if (!wbGapQ) begin
               mem_enable_o = 1'b1;
               mem_addr_o   = {reqTag, reqIdx, 5'b0};
               if (mem_ack_i) begin
                  wrEn      = 1'b1;
                  wrWay     = vicWayQ;
                  wrLineEn  = 1'b1;
                  lruTouch  = 1'b1;
                  lruWay    = vicWayQ;
                  stateNext = REFILL;
               end
            end
         end
         REFILL: begin
            cpu_stall_o = 1'b1;
            stateNext   = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register, latched victim and writeback-to-allocate gap flag
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         vicWayQ <= '0;
         wbGapQ  <= 1'b0;
      end else begin
         state  <= stateNext;
         wbGapQ <= (state == WRITEBACK) && mem_ack_i;
         if (state == IDLE && req && !hit) vicWayQ <= vicWay;
      end
   end

   // LRU ages: touched way becomes youngest, younger ways age by one
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age[s][w] <= AGE_W'(w);
      end else if (lruTouch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == lruWay)
               age[reqIdx][w] <= '0;
            else if (age[reqIdx][w] < age[reqIdx][lruWay])
               age[reqIdx][w] <= age[reqIdx][w] + 1'b1;
         end
      end
   end
endmodule
